// File: rtl/wb_commit_unit.sv
// rtl/wb_commit_unit.sv - writeback commit: value select, conditional commit, regfile, C/Z flags
//
// Purpose: consumes the MEM/WB pipeline register outputs, picks the writeback
// value, decides whether the instruction commits, and updates the 8x16
// register file, the C/Z flags, the last committed PC and the commit counter.
//
// Ports:
//   clk, rst_n                 clock (rising edge), asynchronous active-low reset
//   alu_result_wb              ALU result
//   memrd_data_wb              load data
//   imm9_0_pad_wb              LHI immediate, already padded
//   pc_wb                      PC of the instruction in WB
//   regdst_wb                  destination register
//   regwrite_wb                instruction intends to write (0 = bubble)
//   memtoreg_wb                select load data
//   aluop_wb                   operation code
//   cz_wb, prev_cz_wb          condition field and {C,Z} seen at execute
//   alu_carry_wb               carry-out of the ALU op
//   rd_addr_a/b, rd_data_a/b   ID read ports with write-through bypass
//   wb_en, wb_addr, wb_data    commit strobe, address and value this cycle
//   flag_c, flag_z             architectural flags
//   pc_commit                  PC of the last committed instruction
//   commit_count               number of committed writes (wraps)

module wb_commit_unit #(
  parameter logic [3:0] OP_ADD = 4'b0000,
  parameter logic [3:0] OP_ADI = 4'b0001,
  parameter logic [3:0] OP_NDU = 4'b0010,
  parameter logic [3:0] OP_LHI = 4'b0011,
  parameter logic [3:0] OP_LW  = 4'b0100
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [15:0] alu_result_wb,
  input  logic [15:0] memrd_data_wb,
  input  logic [15:0] imm9_0_pad_wb,
  input  logic [15:0] pc_wb,
  input  logic [2:0]  regdst_wb,
  input  logic        regwrite_wb,
  input  logic        memtoreg_wb,
  input  logic [3:0]  aluop_wb,
  input  logic [1:0]  cz_wb,
  input  logic [1:0]  prev_cz_wb,
  input  logic        alu_carry_wb,
  input  logic [2:0]  rd_addr_a,
  input  logic [2:0]  rd_addr_b,
  output logic [15:0] rd_data_a,
  output logic [15:0] rd_data_b,
  output logic        wb_en,
  output logic [2:0]  wb_addr,
  output logic [15:0] wb_data,
  output logic        flag_c,
  output logic        flag_z,
  output logic [15:0] pc_commit,
  output logic [15:0] commit_count
);

  logic [15:0] regs [8];
  logic        cond_ok;
  logic        is_cond_op;

  always_comb begin
    wb_data = alu_result_wb;
    if (memtoreg_wb) begin
      wb_data = memrd_data_wb;
    end else if (aluop_wb == OP_LHI) begin
      wb_data = imm9_0_pad_wb;
    end
  end

  // Only the ADD and NDU families are predicated on the stored flags.
  always_comb begin
    is_cond_op = (aluop_wb == OP_ADD) || (aluop_wb == OP_NDU);
    cond_ok    = 1'b1;
    if (is_cond_op) begin
      case (cz_wb)
        2'b10:   cond_ok = prev_cz_wb[1];
        2'b01:   cond_ok = prev_cz_wb[0];
        default: cond_ok = 1'b1;
      endcase
    end
  end

  // A bubble (regwrite_wb=0) forces the strobe low regardless of X elsewhere.
  assign wb_en   = rst_n & regwrite_wb & cond_ok;
  assign wb_addr = regdst_wb;

  assign rd_data_a = (wb_en && (rd_addr_a == regdst_wb)) ? wb_data : regs[rd_addr_a];
  assign rd_data_b = (wb_en && (rd_addr_b == regdst_wb)) ? wb_data : regs[rd_addr_b];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 8; i++) begin
        regs[i] <= 16'h0000;
      end
      flag_c       <= 1'b0;
      flag_z       <= 1'b0;
      pc_commit    <= 16'h0000;
      commit_count <= 16'h0000;
    end else if (wb_en) begin
      regs[regdst_wb] <= wb_data;
      pc_commit       <= pc_wb;
      commit_count    <= commit_count + 16'h0001;
      if ((aluop_wb == OP_ADD) || (aluop_wb == OP_ADI)) begin
        flag_c <= alu_carry_wb;
        flag_z <= (wb_data == 16'h0000);
      end else if (aluop_wb == OP_NDU) begin
        flag_z <= (wb_data == 16'h0000);
      end else if ((aluop_wb == OP_LW) && memtoreg_wb) begin
        flag_z <= (memrd_data_wb == 16'h0000);
      end
    end
  end

endmodule

// File: tb/tb_wb_commit_unit.sv
// tb/tb_wb_commit_unit.sv - self-checking bench for wb_commit_unit

module tb_wb_commit_unit;

  localparam logic [3:0] ADD = 4'b0000;
  localparam logic [3:0] ADI = 4'b0001;
  localparam logic [3:0] NDU = 4'b0010;
  localparam logic [3:0] LHI = 4'b0011;
  localparam logic [3:0] LW  = 4'b0100;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [15:0] alu_result_wb, memrd_data_wb, imm9_0_pad_wb, pc_wb;
  logic [2:0]  regdst_wb;
  logic        regwrite_wb, memtoreg_wb;
  logic [3:0]  aluop_wb;
  logic [1:0]  cz_wb, prev_cz_wb;
  logic        alu_carry_wb;
  logic [2:0]  rd_addr_a, rd_addr_b;
  logic [15:0] rd_data_a, rd_data_b;
  logic        wb_en;
  logic [2:0]  wb_addr;
  logic [15:0] wb_data;
  logic        flag_c, flag_z;
  logic [15:0] pc_commit, commit_count;

  int checks = 0;
  int errors = 0;

  wb_commit_unit dut (
    .clk(clk), .rst_n(rst_n),
    .alu_result_wb(alu_result_wb), .memrd_data_wb(memrd_data_wb),
    .imm9_0_pad_wb(imm9_0_pad_wb), .pc_wb(pc_wb),
    .regdst_wb(regdst_wb), .regwrite_wb(regwrite_wb), .memtoreg_wb(memtoreg_wb),
    .aluop_wb(aluop_wb), .cz_wb(cz_wb), .prev_cz_wb(prev_cz_wb),
    .alu_carry_wb(alu_carry_wb),
    .rd_addr_a(rd_addr_a), .rd_addr_b(rd_addr_b),
    .rd_data_a(rd_data_a), .rd_data_b(rd_data_b),
    .wb_en(wb_en), .wb_addr(wb_addr), .wb_data(wb_data),
    .flag_c(flag_c), .flag_z(flag_z),
    .pc_commit(pc_commit), .commit_count(commit_count)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  logic [15:0] m_reg [8];
  logic        m_c, m_z;
  logic [15:0] m_pc, m_count;

  function automatic bit m_commits();
    bit ok;
    if (!(rst_n === 1'b1) || !(regwrite_wb === 1'b1)) return 0;
    ok = 1;
    if (aluop_wb == ADD || aluop_wb == NDU) begin
      if (cz_wb == 2'b10) ok = prev_cz_wb[1];
      else if (cz_wb == 2'b01) ok = prev_cz_wb[0];
    end
    return ok;
  endfunction

  function automatic logic [15:0] m_value();
    if (memtoreg_wb) return memrd_data_wb;
    if (aluop_wb == LHI) return imm9_0_pad_wb;
    return alu_result_wb;
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 8; i++) m_reg[i] = 16'h0;
      m_c = 0; m_z = 0; m_pc = 0; m_count = 0;
    end else if (m_commits()) begin
      logic [15:0] v;
      v = m_value();
      m_reg[regdst_wb] = v;
      m_count = m_count + 1;
      m_pc = pc_wb;
      case (aluop_wb)
        ADD, ADI: begin m_c = alu_carry_wb; m_z = (v == 0); end
        NDU:      m_z = (v == 0);
        LW:       if (memtoreg_wb) m_z = (memrd_data_wb == 0);
        default:  ;
      endcase
    end
  end

  // Compare process: outputs checked mid-cycle on every falling edge.
  always @(negedge clk) begin
    logic en;
    en = m_commits();
    check("wb_en", {15'b0, wb_en}, {15'b0, en});
    if (en) begin
      check("wb_addr", {13'b0, wb_addr}, {13'b0, regdst_wb});
      check("wb_data", wb_data, m_value());
    end
    check("rd_data_a", rd_data_a, (en && rd_addr_a == regdst_wb) ? m_value() : m_reg[rd_addr_a]);
    check("rd_data_b", rd_data_b, (en && rd_addr_b == regdst_wb) ? m_value() : m_reg[rd_addr_b]);
    check("flag_c", {15'b0, flag_c}, {15'b0, m_c});
    check("flag_z", {15'b0, flag_z}, {15'b0, m_z});
    check("pc_commit", pc_commit, m_pc);
    check("commit_count", commit_count, m_count);
  end

  // ---------------- stimulus ----------------
  task automatic drive(input logic [3:0] op, input logic [2:0] rd, input logic rw, input logic mtr,
                       input logic [15:0] alu, input logic [15:0] mem, input logic [15:0] imm,
                       input logic [1:0] cz, input logic [1:0] pcz, input logic carry,
                       input logic [15:0] pc);
    aluop_wb = op; regdst_wb = rd; regwrite_wb = rw; memtoreg_wb = mtr;
    alu_result_wb = alu; memrd_data_wb = mem; imm9_0_pad_wb = imm;
    cz_wb = cz; prev_cz_wb = pcz; alu_carry_wb = carry; pc_wb = pc;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic bubble();
    regwrite_wb = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0;
    rd_addr_a = 3'd0; rd_addr_b = 3'd0;
    drive(ADD, 3'd1, 1'b1, 1'b0, 16'h5555, 16'h0, 16'h0, 2'b00, 2'b00, 1'b1, 16'h0);
    #2;
    check("reset_wb_en_forced", {15'b0, wb_en}, 16'h0);
    check("reset_count", commit_count, 16'h0);
    check("reset_rd_a", rd_data_a, 16'h0);
    bubble();
    #5 rst_n = 1'b1;
    tick();

    // R3=1234 with carry so flag_c is set, then reset between edges
    drive(ADI, 3'd3, 1'b1, 1'b0, 16'h1234, 16'h0, 16'h0, 2'b00, 2'b00, 1'b1, 16'h0010);
    tick();
    bubble(); rd_addr_a = 3'd3;
    #1;
    check("r3_written", rd_data_a, 16'h1234);
    check("r3_flag_c", {15'b0, flag_c}, 16'h1);
    #1 rst_n = 1'b0;
    #1;
    check("async_r3", rd_data_a, 16'h0);
    check("async_flag_c", {15'b0, flag_c}, 16'h0);
    check("async_count", commit_count, 16'h0);
    #4 rst_n = 1'b1;
    tick();

    // ADD zero result with carry
    rd_addr_a = 3'd5; rd_addr_b = 3'd5;
    drive(ADD, 3'd5, 1'b1, 1'b0, 16'h0000, 16'h0, 16'h0, 2'b00, 2'b00, 1'b1, 16'h0100);
    tick();
    check("add_flag_c", {15'b0, flag_c}, 16'h1);
    check("add_flag_z", {15'b0, flag_z}, 16'h1);
    check("add_count", commit_count, 16'h1);
    check("add_pc", pc_commit, 16'h0100);

    // conditional on C, C clear: suppressed
    drive(ADD, 3'd5, 1'b1, 1'b0, 16'h7777, 16'h0, 16'h0, 2'b10, 2'b00, 1'b0, 16'h0102);
    #1;
    check("suppress_wb_en", {15'b0, wb_en}, 16'h0);
    tick();
    check("suppress_r5", rd_data_a, 16'h0);
    check("suppress_count", commit_count, 16'h1);
    // conditional on C, C set: commits
    drive(ADD, 3'd5, 1'b1, 1'b0, 16'h7777, 16'h0, 16'h0, 2'b10, 2'b10, 1'b0, 16'h0104);
    tick();
    bubble();
    #1;
    check("cond_r5", rd_data_a, 16'h7777);
    check("cond_count", commit_count, 16'h2);
    // conditional on Z, NDU, Z clear: suppressed
    drive(NDU, 3'd5, 1'b1, 1'b0, 16'h0000, 16'h0, 16'h0, 2'b01, 2'b10, 1'b0, 16'h0106);
    tick();

    // LW zero with carry input ignored, then LHI
    rd_addr_a = 3'd1; rd_addr_b = 3'd5;
    drive(LW, 3'd1, 1'b1, 1'b1, 16'hBEEF, 16'h0000, 16'h0, 2'b00, 2'b00, 1'b1, 16'h0108);
    tick();
    check("lw_flag_z", {15'b0, flag_z}, 16'h1);
    check("lw_flag_c_held", {15'b0, flag_c}, 16'h0);
    drive(LHI, 3'd1, 1'b1, 1'b0, 16'h1111, 16'h2222, 16'hAB80, 2'b00, 2'b00, 1'b1, 16'h010A);
    tick();
    bubble();
    #1;
    check("lhi_r1", rd_data_a, 16'hAB80);
    check("lhi_flag_z_held", {15'b0, flag_z}, 16'h1);

    // NDU zero, C held
    drive(NDU, 3'd4, 1'b1, 1'b0, 16'h0000, 16'h0, 16'h0, 2'b00, 2'b00, 1'b1, 16'h010C);
    tick();

    // Bypass on both ports
    rd_addr_a = 3'd2; rd_addr_b = 3'd2;
    drive(ADI, 3'd2, 1'b1, 1'b0, 16'h00FF, 16'h0, 16'h0, 2'b00, 2'b00, 1'b0, 16'h010E);
    #1;
    check("bypass_a", rd_data_a, 16'h00FF);
    check("bypass_b", rd_data_b, 16'h00FF);
    tick();

    // R7 back-to-back, ADI ignores condition
    rd_addr_a = 3'd7; rd_addr_b = 3'd4;
    drive(ADI, 3'd7, 1'b1, 1'b0, 16'h1111, 16'h0, 16'h0, 2'b10, 2'b00, 1'b0, 16'h0110);
    tick();
    drive(ADI, 3'd7, 1'b1, 1'b0, 16'h2222, 16'h0, 16'h0, 2'b01, 2'b00, 1'b1, 16'h0112);
    tick();
    bubble();
    #1;
    check("r7_last_wins", rd_data_a, 16'h2222);

    // X on everything but regwrite during a bubble
    drive(4'bx, 3'bx, 1'b0, 1'bx, 16'hx, 16'hx, 16'hx, 2'bx, 2'bx, 1'bx, 16'hx);
    tick();
    tick();

    // Counter wrap with bubbles interleaved
    rd_addr_a = 3'd6; rd_addr_b = 3'd0;
    drive(ADI, 3'd6, 1'b1, 1'b0, 16'h0042, 16'h0, 16'h0, 2'b00, 2'b00, 1'b0, 16'h0200);
    repeat (int'(16'hFFFF - m_count)) @(posedge clk);
    #1;
    check("count_ffff", commit_count, 16'hFFFF);
    bubble();
    tick();
    tick();
    check("bubble_no_count", commit_count, 16'hFFFF);
    regwrite_wb = 1'b1;
    tick();
    check("count_wrap", commit_count, 16'h0000);
    bubble();
    tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
